i2s_mic_rx: RTL and testbench

- I2S master receiver at the front of the spectrometer; it is the first stage inside the spectrometer top.
- Generates SCK and WS for the MEMS microphone (real or simulation model) and deserialises SD into signed PCM samples.
- Presents samples on a valid/ready interface to the downstream windowing/FFT stage.
- Holds one sample, flags overflow, and discards the microphone wake-up frames after reset.

---
 rtl/i2s_pkg.sv | 15 +
 rtl/i2s_clk_gen.sv | 58 +++++
 rtl/i2s_mic_rx.sv | 169 ++++++++++++++++
 tb/tb_i2s_mic_rx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants and types for the I2S microphone receiver.
//   SLOTS_PER_CH / FRAME_SLOTS / SLOT_W describe the 64-slot I2S frame.
//   CH_LEFT / CH_RIGHT encode the channel carried by WS (and sample_chan).
package i2s_pkg;

  localparam int SLOTS_PER_CH = 32;
  localparam int FRAME_SLOTS  = 64;
  localparam int SLOT_W       = 6;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef logic [SLOT_W-1:0] slot_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: bit clock, word select and slot timing for the I2S master.
//   clk, reset : system clock, synchronous active-high reset
//   SCK        : bit clock, clk / (2*HALF_DIV)
//   WS         : word select (slot[5]); changes only as SCK falls
//   rise_evt   : single-cycle strobe, the cycle before SCK rises
//   fall_evt   : single-cycle strobe, the cycle before SCK falls
//   slot       : current slot index 0..63 within the frame
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int HALF_DIV = 16
) (
  input  logic  clk,
  input  logic  reset,
  output logic  SCK,
  output logic  WS,
  output logic  rise_evt,
  output logic  fall_evt,
  output slot_t slot
);

  localparam int               DIV_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic             sck_reg;
  slot_t            slot_reg;
  logic             wrap;

  assign wrap     = (div_cnt_reg == DIV_LAST);
  // The strobes are qualified by the current SCK level: the wrap cycle with
  // SCK low is the one whose clock edge drives SCK high, and vice versa.
  assign rise_evt = wrap & ~sck_reg;
  assign fall_evt = wrap & sck_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_reg <= '0;
      sck_reg     <= 1'b0;
      slot_reg    <= '0;
    end else begin
      div_cnt_reg <= wrap ? '0 : div_cnt_reg + DIV_W'(1);
      if (wrap) begin
        sck_reg <= ~sck_reg;
      end
      // Slot advances with SCK falling so WS (slot MSB) follows the I2S rule
      // of changing on the falling edge; 63 wraps naturally to 0.
      if (fall_evt) begin
        slot_reg <= slot_reg + SLOT_W'(1);
      end
    end
  end

  assign SCK  = sck_reg;
  assign WS   = slot_reg[SLOT_W-1];
  assign slot = slot_reg;

endmodule

// File: rtl/i2s_mic_rx.sv
// i2s_mic_rx: I2S master receiver for a MEMS microphone.
// Generates SCK/WS, deserialises SD (MSB first, one-slot I2S delay) into
// signed DATA_W-bit samples, and offers them on a valid/ready interface with
// a single holding register, a sticky overflow flag and a startup discard of
// STARTUP_FRAMES whole frames.
//   clk, reset   : system clock, synchronous active-high reset
//   SCK, WS      : bit clock and word select to the microphone
//   SD           : serial data from the microphone
//   sample_data  : held sample (two's complement)
//   sample_valid : sample_data holds an unconsumed sample
//   sample_ready : downstream accepts the sample
//   overflow     : sticky, a completed sample was dropped
//   sample_chan  : channel of the held sample (only with I2S_RX_STEREO_EN)
// Build option: define I2S_RX_STEREO_EN to capture the right channel too.
module i2s_mic_rx
  import i2s_pkg::*;
#(
  parameter int HALF_DIV       = 16,
  parameter int DATA_W         = 24,
  parameter int STARTUP_FRAMES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     SCK,
  output logic                     WS,
  input  logic                     SD,
  output logic signed [DATA_W-1:0] sample_data,
  output logic                     sample_valid,
  input  logic                     sample_ready,
`ifdef I2S_RX_STEREO_EN
  output logic                     sample_chan,
`endif
  output logic                     overflow
);

  localparam int              CH_W       = $clog2(SLOTS_PER_CH);
  localparam logic [CH_W-1:0] LAST_SLOT  = CH_W'(DATA_W);
  localparam int              SU_W       = (STARTUP_FRAMES > 0) ? $clog2(STARTUP_FRAMES + 1) : 1;
  localparam slot_t           FRAME_LAST = slot_t'(FRAME_SLOTS - 1);

  logic  rise_evt;
  logic  fall_evt;
  slot_t slot;

  i2s_clk_gen #(
    .HALF_DIV(HALF_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .reset    (reset),
    .SCK      (SCK),
    .WS       (WS),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt),
    .slot     (slot)
  );

  logic [CH_W-1:0] ch_slot;
  logic            ch_sel;
  logic            ch_enabled;
  logic            bit_slot;
  logic            capture;
  logic            word_done;
  logic            frame_wrap;
  logic            discard;

  assign ch_slot = slot[CH_W-1:0];
  assign ch_sel  = slot[SLOT_W-1];

`ifdef I2S_RX_STEREO_EN
  assign ch_enabled = 1'b1;
`else
  assign ch_enabled = (ch_sel == CH_LEFT);
`endif

  // Channel slot 0 is the I2S delay bit; slots beyond DATA_W are padding.
  assign bit_slot   = (ch_slot != '0) && (ch_slot <= LAST_SLOT);
  assign capture    = rise_evt & bit_slot & ch_enabled;
  assign word_done  = capture & (ch_slot == LAST_SLOT);
  assign frame_wrap = fall_evt & (slot == FRAME_LAST);

  logic [DATA_W-1:0] shift_reg, shift_next;
  logic              done_reg;
  logic [SU_W-1:0]   su_reg, su_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic              valid_reg, valid_next;
  logic              ovf_reg, ovf_next;
`ifdef I2S_RX_STEREO_EN
  logic              done_chan_reg;
  logic              chan_reg, chan_next;
`endif

  assign discard = (su_reg != '0);

  always_comb begin
    shift_next = shift_reg;
    if (capture) begin
      shift_next = (shift_reg << 1) | DATA_W'(SD);
    end
  end

  always_comb begin
    su_next = su_reg;
    if (frame_wrap && discard) begin
      su_next = su_reg - SU_W'(1);
    end
  end

  // done_reg marks the cycle after the LSB was shifted in: shift_reg now holds
  // the whole word. A transfer in the same cycle frees the holding register,
  // so the new word loads without a bubble instead of being dropped.
  always_comb begin
    data_next  = data_reg;
    valid_next = valid_reg;
    ovf_next   = ovf_reg;
`ifdef I2S_RX_STEREO_EN
    chan_next  = chan_reg;
`endif
    if (valid_reg && sample_ready) begin
      valid_next = 1'b0;
    end
    if (done_reg && !discard) begin
      if (!valid_reg || sample_ready) begin
        data_next  = shift_reg;
        valid_next = 1'b1;
`ifdef I2S_RX_STEREO_EN
        chan_next  = done_chan_reg;
`endif
      end else begin
        ovf_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg     <= '0;
      done_reg      <= 1'b0;
      su_reg        <= SU_W'(STARTUP_FRAMES);
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      ovf_reg       <= 1'b0;
`ifdef I2S_RX_STEREO_EN
      done_chan_reg <= CH_LEFT;
      chan_reg      <= CH_LEFT;
`endif
    end else begin
      shift_reg     <= shift_next;
      done_reg      <= word_done;
      su_reg        <= su_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      ovf_reg       <= ovf_next;
`ifdef I2S_RX_STEREO_EN
      if (word_done) begin
        done_chan_reg <= ch_sel;
      end
      chan_reg      <= chan_next;
`endif
    end
  end

  assign sample_data  = data_reg;
  assign sample_valid = valid_reg;
  assign overflow     = ovf_reg;
`ifdef I2S_RX_STEREO_EN
  assign sample_chan  = chan_reg;
`endif

endmodule

// File: tb/tb_i2s_mic_rx.sv
// tb_i2s_mic_rx: directed self-checking bench for i2s_mic_rx.
// Two receivers (STARTUP_FRAMES 0 and 2) share clk, reset and one
// microphone model; with HALF_DIV=2 both produce identical SCK/WS timing.
// Cycle S0 is the cycle right after a reset edge; slot n spans S4n..S4n+3,
// its rise strobe is S4n+1, and a frame is 256 clk.
module tb_i2s_mic_rx;

  localparam int HD = 2;
  localparam int DW = 24;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic SD;
  always #5 clk = ~clk;

  logic                 sck0, ws0, valid0, ovf0, ready0;
  logic signed [DW-1:0] data0;
  logic                 sck2, ws2, valid2, ovf2, ready2;
  logic signed [DW-1:0] data2;
`ifdef I2S_RX_STEREO_EN
  logic                 chan0, chan2;
`endif

  i2s_mic_rx #(.HALF_DIV(HD), .DATA_W(DW), .STARTUP_FRAMES(0)) dut0 (
    .clk(clk), .reset(reset), .SCK(sck0), .WS(ws0), .SD(SD),
    .sample_data(data0), .sample_valid(valid0), .sample_ready(ready0),
`ifdef I2S_RX_STEREO_EN
    .sample_chan(chan0),
`endif
    .overflow(ovf0));

  i2s_mic_rx #(.HALF_DIV(HD), .DATA_W(DW), .STARTUP_FRAMES(2)) dut2 (
    .clk(clk), .reset(reset), .SCK(sck2), .WS(ws2), .SD(SD),
    .sample_data(data2), .sample_valid(valid2), .sample_ready(ready2),
`ifdef I2S_RX_STEREO_EN
    .sample_chan(chan2),
`endif
    .overflow(ovf2));

  int n_cmp = 0;
  int n_bad = 0;

  // Left word per frame: constant 0x800001, or a distinct word per frame.
  logic vary = 1'b0;
  function automatic logic [23:0] left_of(input logic v, input int f);
    if (v) return 24'h5A0000 + 24'(f) * 24'h010203;
    return 24'h800001;
  endfunction

  // Microphone model: counts SCK falling edges into its own slot/frame
  // counters and drives the bit for that slot (MSB in channel slot 1).
  logic [5:0]  m_slot;
  logic        m_sck_d;
  int          m_frame;
  logic [23:0] m_word;
  int          m_ch;

  always @(posedge clk) begin
    if (reset) begin
      m_slot  <= 6'd0;
      m_sck_d <= 1'b0;
      m_frame <= 0;
    end else begin
      m_sck_d <= sck0;
      if (m_sck_d && !sck0) begin
        m_slot <= m_slot + 6'd1;
        if (m_slot == 6'd63) m_frame <= m_frame + 1;
      end
    end
  end

  always_comb begin
    m_ch   = int'(m_slot[4:0]);
    m_word = m_slot[5] ? 24'h123456 : left_of(vary, m_frame);
    SD     = 1'b0;
    if (m_ch >= 1 && m_ch <= DW) SD = m_word[DW - m_ch];
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge of S0 with reset released.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    ready0 = 1'b0;
    ready2 = 1'b1;
    reset  = 1'b1;
    step(2);
    n_cmp++; if (sck0 !== 1'b0) begin n_bad++; $display("FAIL reset_sck: got %b want 0", sck0); end
    n_cmp++; if (ws0 !== 1'b0) begin n_bad++; $display("FAIL reset_ws: got %b want 0", ws0); end
    n_cmp++; if (data0 !== 24'h0) begin n_bad++; $display("FAIL reset_data: got %h want 000000", data0); end
    n_cmp++; if (valid0 !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid0); end
    n_cmp++; if (ovf0 !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf0); end
    n_cmp++; if (valid2 !== 1'b0 || ovf2 !== 1'b0) begin n_bad++; $display("FAIL reset_dut2: got valid %b ovf %b want 0 0", valid2, ovf2); end
    $display("test_reset: outputs at reset checked");
  endtask

  task automatic test_clock_framing();
    int   rises, first_rise, last_rise, bad_period;
    int   ws_chg, ws_first, ws_second, ws_off_edge, first_valid, rises_at_valid;
    logic p_sck, p_ws;
    vary = 1'b0; ready0 = 1'b1;
    do_reset();
    rises = 0; first_rise = -1; last_rise = -1; bad_period = 0;
    ws_chg = 0; ws_first = -1; ws_second = -1; ws_off_edge = 0;
    first_valid = -1; rises_at_valid = -1;
    p_sck = sck0; p_ws = ws0;
    for (int i = 1; i <= 300; i++) begin
      step(1);
      if (sck0 && !p_sck) begin
        rises++;
        if (last_rise >= 0 && (i - last_rise) != 4) bad_period++;
        if (last_rise < 0) first_rise = i;
        last_rise = i;
      end
      if (ws0 !== p_ws) begin
        ws_chg++;
        if (!(p_sck && !sck0)) ws_off_edge++;
        if (ws_first < 0) ws_first = i;
        else if (ws_second < 0) ws_second = i;
      end
      if (valid0 && first_valid < 0) begin
        first_valid = i;
        rises_at_valid = rises;
      end
      p_sck = sck0; p_ws = ws0;
    end
    n_cmp++; if (first_rise != 2) begin n_bad++; $display("FAIL sck_first_rise: got %0d want 2", first_rise); end
    n_cmp++; if (bad_period != 0) begin n_bad++; $display("FAIL sck_period: got %0d non-4-clk periods want 0", bad_period); end
    n_cmp++; if (ws_first != 128 || ws_second != 256) begin n_bad++; $display("FAIL ws_toggle: got %0d,%0d want 128,256", ws_first, ws_second); end
    n_cmp++; if (ws_chg != 2 || ws_off_edge != 0) begin n_bad++; $display("FAIL ws_on_fall: got %0d changes %0d off-edge want 2 0", ws_chg, ws_off_edge); end
    n_cmp++; if (first_valid != 99) begin n_bad++; $display("FAIL first_valid_cycle: got %0d want 99", first_valid); end
    n_cmp++; if (rises_at_valid != 25) begin n_bad++; $display("FAIL sck_rises_before_valid: got %0d want 25", rises_at_valid); end
    $display("test_clock_framing: first valid at cycle %0d", first_valid);
  endtask

  task automatic test_basic();
    int n_xfer, last_xfer, bad_gap, seen_right;
    vary = 1'b0; ready0 = 1'b1;
    do_reset();
    n_xfer = 0; last_xfer = -1; bad_gap = 0; seen_right = 0;
    for (int i = 1; i <= 800; i++) begin
      step(1);
      if (data0 === 24'h123456) seen_right++;
      if (valid0 && ready0) begin
        $display("basic: sample %h (%0d) at cycle %0d", data0, int'(data0), i);
        n_cmp++; if (int'(data0) !== -8388607) begin n_bad++; $display("FAIL basic_data: got %0d want -8388607", int'(data0)); end
        if (last_xfer >= 0 && (i - last_xfer) != 256) bad_gap++;
        last_xfer = i;
        n_xfer++;
      end
    end
    n_cmp++; if (n_xfer != 3) begin n_bad++; $display("FAIL basic_count: got %0d want 3", n_xfer); end
    n_cmp++; if (bad_gap != 0) begin n_bad++; $display("FAIL basic_spacing: got %0d gaps not 256 want 0", bad_gap); end
    n_cmp++; if (seen_right != 0) begin n_bad++; $display("FAIL basic_no_right: got %0d cycles with 123456 want 0", seen_right); end
    n_cmp++; if (ovf0 !== 1'b0) begin n_bad++; $display("FAIL basic_ovf: got %b want 0", ovf0); end
  endtask

  task automatic test_startup();
    int first;
    vary = 1'b1; ready2 = 1'b1;
    do_reset();
    first = -1;
    for (int i = 1; i <= 700 && first < 0; i++) begin
      step(1);
      if (valid2) first = i;
    end
    n_cmp++; if (first != 611) begin n_bad++; $display("FAIL startup_first_valid: got %0d want 611", first); end
    n_cmp++; if (data2 !== left_of(1'b1, 2)) begin n_bad++; $display("FAIL startup_data: got %h want %h", data2, left_of(1'b1, 2)); end
    n_cmp++; if (ovf2 !== 1'b0) begin n_bad++; $display("FAIL startup_ovf: got %b want 0", ovf2); end
    $display("startup: first sample %h at cycle %0d", data2, first);
  endtask

  task automatic test_backpressure();
    int found;
    vary = 1'b1; ready0 = 1'b0;
    do_reset();
    step(300);
    n_cmp++; if (valid0 !== 1'b1 || data0 !== left_of(1'b1, 0) || ovf0 !== 1'b0) begin n_bad++; $display("FAIL bp_hold_a: got v%b %h ovf%b want v1 %h ovf0", valid0, data0, ovf0, left_of(1'b1, 0)); end
    step(56);
    n_cmp++; if (ovf0 !== 1'b1 || data0 !== left_of(1'b1, 0)) begin n_bad++; $display("FAIL bp_after_b: got %h ovf%b want %h ovf1", data0, ovf0, left_of(1'b1, 0)); end
    step(344);
    n_cmp++; if (valid0 !== 1'b1 || data0 !== left_of(1'b1, 0) || ovf0 !== 1'b1) begin n_bad++; $display("FAIL bp_after_c: got v%b %h ovf%b want v1 %h ovf1", valid0, data0, ovf0, left_of(1'b1, 0)); end
    ready0 = 1'b1;
    step(1);
    n_cmp++; if (valid0 !== 1'b0) begin n_bad++; $display("FAIL bp_release: got valid %b want 0", valid0); end
    found = -1;
    for (int i = 702; i <= 1000 && found < 0; i++) begin
      step(1);
      if (valid0) found = i;
    end
    n_cmp++; if (found != 867) begin n_bad++; $display("FAIL bp_next_cycle: got %0d want 867", found); end
    n_cmp++; if (data0 !== left_of(1'b1, 3)) begin n_bad++; $display("FAIL bp_next_data: got %h want %h", data0, left_of(1'b1, 3)); end
    $display("backpressure: next sample %h at cycle %0d", data0, found);
  endtask

  task automatic test_back_to_back();
    vary = 1'b1; ready0 = 1'b0;
    do_reset();
    step(354);
    n_cmp++; if (valid0 !== 1'b1 || data0 !== left_of(1'b1, 0)) begin n_bad++; $display("FAIL b2b_before: got v%b %h want v1 %h", valid0, data0, left_of(1'b1, 0)); end
    ready0 = 1'b1;
    step(1);
    ready0 = 1'b0;
    n_cmp++; if (valid0 !== 1'b1 || data0 !== left_of(1'b1, 1)) begin n_bad++; $display("FAIL b2b_load: got v%b %h want v1 %h", valid0, data0, left_of(1'b1, 1)); end
    n_cmp++; if (ovf0 !== 1'b0) begin n_bad++; $display("FAIL b2b_ovf: got %b want 0", ovf0); end
    step(5);
    n_cmp++; if (valid0 !== 1'b1 || data0 !== left_of(1'b1, 1)) begin n_bad++; $display("FAIL b2b_hold: got v%b %h want v1 %h", valid0, data0, left_of(1'b1, 1)); end
    $display("back_to_back: sample %h loaded in transfer cycle", data0);
  endtask

  task automatic test_reset_midword();
    int found;
    vary = 1'b1; ready0 = 1'b0;
    do_reset();
    step(554);
    n_cmp++; if (valid0 !== 1'b1 || ovf0 !== 1'b1 || sck0 !== 1'b1) begin n_bad++; $display("FAIL midrst_pre: got v%b ovf%b sck%b want 1 1 1", valid0, ovf0, sck0); end
    reset = 1'b1;
    step(1);
    n_cmp++; if (sck0 !== 1'b0 || ws0 !== 1'b0 || valid0 !== 1'b0 || ovf0 !== 1'b0 || data0 !== 24'h0) begin
      n_bad++; $display("FAIL midrst_outputs: got sck%b ws%b v%b ovf%b %h want 0 0 0 0 000000", sck0, ws0, valid0, ovf0, data0);
    end
    reset = 1'b0;
    ready0 = 1'b1;
    found = -1;
    for (int i = 1; i <= 300 && found < 0; i++) begin
      step(1);
      if (valid0) found = i;
    end
    n_cmp++; if (found != 99) begin n_bad++; $display("FAIL midrst_cycle: got %0d want 99", found); end
    n_cmp++; if (data0 !== left_of(1'b1, 0)) begin n_bad++; $display("FAIL midrst_data: got %h want %h", data0, left_of(1'b1, 0)); end
    $display("reset_midword: sample %h at cycle %0d", data0, found);
  endtask

`ifdef I2S_RX_STEREO_EN
  task automatic test_stereo();
    int k;
    int at[3];
    logic [23:0] dv[3];
    logic ch[3];
    vary = 1'b0; ready0 = 1'b1;
    do_reset();
    k = 0;
    for (int i = 1; i <= 400 && k < 3; i++) begin
      step(1);
      if (valid0) begin
        at[k] = i; dv[k] = data0; ch[k] = chan0;
        $display("stereo: sample %h chan %b at cycle %0d", data0, chan0, i);
        k++;
      end
    end
    n_cmp++; if (k != 3) begin n_bad++; $display("FAIL stereo_count: got %0d want 3", k); end
    if (k == 3) begin
      n_cmp++; if (at[0] != 99 || at[1] != 227 || at[2] != 355) begin n_bad++; $display("FAIL stereo_timing: got %0d,%0d,%0d want 99,227,355", at[0], at[1], at[2]); end
      n_cmp++; if (dv[0] !== 24'h800001 || ch[0] !== 1'b0) begin n_bad++; $display("FAIL stereo_left: got %h ch%b want 800001 ch0", dv[0], ch[0]); end
      n_cmp++; if (dv[1] !== 24'h123456 || ch[1] !== 1'b1) begin n_bad++; $display("FAIL stereo_right: got %h ch%b want 123456 ch1", dv[1], ch[1]); end
      n_cmp++; if (dv[2] !== 24'h800001 || ch[2] !== 1'b0) begin n_bad++; $display("FAIL stereo_left2: got %h ch%b want 800001 ch0", dv[2], ch[2]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clock_framing();
`ifdef I2S_RX_STEREO_EN
    test_stereo();
`else
    test_basic();
    test_startup();
    test_backpressure();
    test_back_to_back();
    test_reset_midword();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
